imem_loader: RTL and testbench

Instruction-memory loader for the single-cycle MIPS datapath: the write side of the instruction memory the processor fetches from. It accepts a byte stream over a valid/ready handshake, writes it big-endian into a byte-wide instruction store, and raises `cpu_run` once the image is complete. While `cpu_run` is low, the processor is held at PC 0. A combinational 4-byte fetch port serves the processor from the same store.

---
 rtl/imem_loader_pkg.sv | 19 +
 rtl/imem_byte_store.sv | 38 +++
 rtl/imem_loader.sv | 130 +++++++++++++
 tb/tb_imem_loader.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Checksum support is selected by IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

  localparam int unsigned DefaultDepth = 32;

  typedef enum logic [2:0] {
    StHdr,
    StLoad,
    StChk,
    StRun,
    StErr
  } state_e;

  function automatic int unsigned addr_width(input int unsigned depth);
    return unsigned'($clog2(depth));
  endfunction

endpackage

// File: rtl/imem_byte_store.sv
// Byte-wide instruction store: one write port, combinational big-endian
// 4-byte read that wraps around the top of the array.
module imem_byte_store #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'd0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Index arithmetic stays AW bits wide, so addresses wrap mod DEPTH.
  logic [AW-1:0] raddr1, raddr2, raddr3;

  always_comb begin
    raddr1 = raddr + AW'(1);
    raddr2 = raddr + AW'(2);
    raddr3 = raddr + AW'(3);
    rdata  = {mem_q[raddr], mem_q[raddr1], mem_q[raddr2], mem_q[raddr3]};
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: length-prefixed byte stream into the store,
// cpu_run once complete. Optional checksum byte via IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH = DefaultDepth,
  localparam int unsigned AW   = addr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          load_req,
  input  logic [AW-1:0] fetch_addr,
  output logic [31:0]   fetch_data,
  output logic          cpu_run,
  output logic          load_err,
  output logic [AW:0]   load_count
);

  localparam logic [AW:0] CountOne = (AW + 1)'(1);
  localparam logic [8:0]  DepthLen = 9'(DEPTH);

  state_e      state_q, state_d;
  logic [AW:0] count_q, count_d;
  logic [AW:0] len_q, len_d;
  logic [8:0]  hdr_len;
  logic        accept;
  logic        wr_en;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= 8'd0;
    end else begin
      sum_q <= sum_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StHdr;
      count_q <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      len_q   <= len_d;
    end
  end

  // A zero length byte stands for a full store.
  assign hdr_len = (in_data == 8'd0) ? DepthLen : {1'b0, in_data};
  assign accept  = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    len_d   = len_q;
    wr_en   = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    if (load_req) begin
      state_d = StHdr;
      count_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_d   = 8'd0;
`endif
    end else if (accept) begin
      unique case (state_q)
        StHdr: begin
          count_d = '0;
          if (hdr_len > DepthLen) begin
            state_d = StErr;
          end else begin
            len_d   = hdr_len[AW:0];
            state_d = StLoad;
          end
        end
        StLoad: begin
          wr_en   = 1'b1;
          count_d = count_q + CountOne;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d   = sum_q + in_data;
          if (count_d == len_q) state_d = StChk;
`else
          if (count_d == len_q) state_d = StRun;
`endif
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        StChk: state_d = ((sum_q + in_data) == 8'd0) ? StRun : StErr;
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready = 1'b0;
    cpu_run  = 1'b0;
    load_err = 1'b0;
    unique case (state_q)
      StHdr, StLoad, StChk: in_ready = 1'b1;
      StRun:                cpu_run  = 1'b1;
      StErr:                load_err = 1'b1;
      default: ;
    endcase
  end

  assign load_count = count_q;

  imem_byte_store #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_store (
    .clk  (clk),
    .rst  (rst),
    .we   (wr_en),
    .waddr(count_q[AW-1:0]),
    .wdata(in_data),
    .raddr(fetch_addr),
    .rdata(fetch_data)
  );

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader against a byte-array model of the store.
module tb_imem_loader;

  localparam int unsigned Depth = 32;
  localparam int unsigned Aw    = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          load_req;
  logic [Aw-1:0] fetch_addr;
  logic [31:0]   fetch_data;
  logic          cpu_run;
  logic          load_err;
  logic [Aw:0]   load_count;

  imem_loader #(.DEPTH(Depth)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .load_req  (load_req),
    .fetch_addr(fetch_addr),
    .fetch_data(fetch_data),
    .cpu_run   (cpu_run),
    .load_err  (load_err),
    .load_count(load_count)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [7:0]  model_mem [Depth];
  logic [7:0]  fixed_img [8] = '{8'h8C, 8'h01, 8'h00, 8'h00, 8'h20, 8'h21, 8'h00, 8'h04};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_fetch(input int a);
    return {model_mem[a % Depth], model_mem[(a + 1) % Depth],
            model_mem[(a + 2) % Depth], model_mem[(a + 3) % Depth]};
  endfunction

  task automatic check_fetch(input string tag, input int a);
    fetch_addr = Aw'(a);
    #1;
    check(tag, fetch_data, ref_fetch(a));
  endtask

  task automatic check_store(input string tag);
    for (int a = 0; a < Depth; a += 3) check_fetch(tag, a);
  endtask

  // One byte on the stream, optionally preceded by idle cycles with in_valid low.
  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) begin
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    check("in_ready_before_byte", in_ready, 1'b1);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic pulse_req();
    load_req = 1'b1;
    @(posedge clk);
    #1;
    load_req = 1'b0;
    check("req_cpu_run", cpu_run, 1'b0);
    check("req_load_err", load_err, 1'b0);
    check("req_load_count", load_count, 0);
    check("req_in_ready", in_ready, 1'b1);
  endtask

  // Full image from HDR; bad_chk corrupts the checksum byte when it exists.
  task automatic load_image(input int n, input logic [7:0] data[$], input bit bad_chk,
                            input int max_gap);
    logic [7:0] sum;
    logic [7:0] lb;
    bit         ok;
    sum = 8'd0;
    ok  = !bad_chk;
    lb  = (n == Depth) ? 8'd0 : 8'(n);
    send(lb, $urandom_range(0, max_gap));
    for (int i = 0; i < n; i++) begin
      check("load_count_step", load_count, i);
      check("cpu_run_early", cpu_run, 1'b0);
      send(data[i], $urandom_range(0, max_gap));
      model_mem[i] = data[i];
      sum          = sum + data[i];
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("cpu_run_before_chk", cpu_run, 1'b0);
    send(bad_chk ? 8'(8'd1 - sum) : 8'(8'd0 - sum), $urandom_range(0, max_gap));
`else
    ok = 1'b1;
`endif
    check("img_cpu_run", cpu_run, ok);
    check("img_load_err", load_err, !ok);
    check("img_in_ready", in_ready, 1'b0);
    check("img_load_count", load_count, n);
  endtask

  task automatic bad_length(input logic [7:0] lb);
    send(lb, 0);
    check("badlen_err", load_err, 1'b1);
    check("badlen_run", cpu_run, 1'b0);
    check("badlen_ready", in_ready, 1'b0);
    check_store("badlen_store");
  endtask

  initial begin
    logic [7:0] img[$];
    int         n;

    rst        = 1'b1;
    in_data    = 8'd0;
    in_valid   = 1'b0;
    load_req   = 1'b0;
    fetch_addr = '0;
    for (int i = 0; i < Depth; i++) model_mem[i] = 8'd0;
    #12;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_cpu_run", cpu_run, 1'b0);
    check("rst_load_err", load_err, 1'b0);
    check("rst_load_count", load_count, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_store("rst_store");

    // Fixed 8-byte program
    img = {};
    for (int i = 0; i < 8; i++) img.push_back(fixed_img[i]);
    load_image(8, img, 1'b0, 0);
    fetch_addr = Aw'(0);
    #1;
    check("fixed_fetch0", fetch_data, 32'h8C010000);
    fetch_addr = Aw'(4);
    #1;
    check("fixed_fetch4", fetch_data, 32'h20210004);
    check_store("fixed_store");

`ifdef IMEM_LOADER_CHECKSUM_EN
    pulse_req();
    load_image(8, img, 1'b1, 0);
`endif
    pulse_req();

    // Oversized length is rejected on the header edge
    bad_length(8'h21);
    pulse_req();
    bad_length(8'(Depth + 1 + $urandom_range(0, 200)));
    pulse_req();

    // Full store, value i in slot i, then a wrapping fetch
    img = {};
    for (int i = 0; i < Depth; i++) img.push_back(8'(i));
    load_image(Depth, img, 1'b0, 0);
    fetch_addr = Aw'(30);
    #1;
    check("wrap_fetch30", fetch_data, 32'h1E1F0001);
    check_fetch("wrap_fetch31", 31);
    pulse_req();

    // load_req collides with the third data byte
    send(8'd4, 0);
    for (int i = 0; i < 2; i++) begin
      model_mem[i] = 8'($urandom);
      send(model_mem[i], 0);
    end
    in_data  = 8'hAA;
    in_valid = 1'b1;
    load_req = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    load_req = 1'b0;
    check("abort_count", load_count, 0);
    check("abort_ready", in_ready, 1'b1);
    check("abort_run", cpu_run, 1'b0);
    check_fetch("abort_fetch0", 0);
    img = {};
    for (int i = 0; i < 4; i++) img.push_back(8'($urandom));
    load_image(4, img, 1'b0, 0);
    check_store("abort_reload_store");
    pulse_req();

    // in_valid toggling every other cycle
    img = {};
    for (int i = 0; i < 6; i++) img.push_back(8'($urandom));
    send(8'd6, 1);
    for (int i = 0; i < 6; i++) begin
      send(img[i], 1);
      model_mem[i] = img[i];
      check("toggle_count", load_count, i + 1);
    end
    check_store("toggle_store");
    pulse_req();

    // Reset in the middle of a load
    send(8'd5, 0);
    for (int i = 0; i < 2; i++) begin
      model_mem[i] = 8'($urandom);
      send(model_mem[i], 1);
    end
    check("midrst_count", load_count, 2);
    rst = 1'b1;
    #2;
    for (int i = 0; i < Depth; i++) model_mem[i] = 8'd0;
    check("midrst_ready", in_ready, 1'b1);
    check("midrst_count0", load_count, 0);
    #1;
    rst = 1'b0;
    check_store("midrst_store");
    @(posedge clk);
    #1;

    // Randomised images with random gaps and occasional bad checksums
    for (int t = 0; t < 8; t++) begin
      n   = $urandom_range(1, Depth);
      img = {};
      for (int i = 0; i < n; i++) img.push_back(8'($urandom));
      load_image(n, img, ($urandom_range(0, 3) == 0), 2);
      check_store("rand_store");
      check_fetch("rand_fetch", $urandom_range(0, Depth - 1));
      pulse_req();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
